// File: rtl/msix_intr_arbiter_if.sv
// Downstream interrupt handshake between the MSI-X arbiter and the INTx/MSI bridge.
interface msix_intr_arbiter_if #(
  parameter int VECW = 2
) ();
  logic            intx_msi_request;
  logic [VECW-1:0] intx_msi_vector;
  logic            intx_msi_grant;

  modport master (
    output intx_msi_request,
    output intx_msi_vector,
    input  intx_msi_grant
  );

  modport slave (
    input  intx_msi_request,
    input  intx_msi_vector,
    output intx_msi_grant
  );
endinterface

// File: rtl/msix_intr_arbiter.sv
// Collects per-vector interrupt events into pending bits and issues them one at a
// time, round-robin, to the downstream bridge with an enforced low gap between requests.
module msix_intr_arbiter #(
  parameter int NVEC          = 4,
  parameter int VECW          = 2,
  parameter int USE_GRANT     = 0,
  parameter int GRANT_TIMEOUT = 16,
  parameter int GAP_CYC       = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NVEC-1:0]            i_irq_src,
  input  logic [NVEC-1:0]            i_vec_mask,
  msix_intr_arbiter_if.master        bus,
  output logic [NVEC-1:0]            o_pending,
  output logic                       o_timeout_err
);

  localparam bit LP_GRANT = (USE_GRANT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [NVEC-1:0] r_pending;
  logic [VECW-1:0] r_rr_ptr;
  logic [VECW-1:0] r_vec;
  logic            r_req;
  logic            r_tmo_err;
  logic [7:0]      r_tmo_cnt;
  logic [3:0]      r_gap_cnt;

  logic [NVEC-1:0] w_elig;
  logic [NVEC-1:0] w_clr;
  logic [VECW:0]   w_idx;
  logic [VECW-1:0] w_sel;
  logic [VECW-1:0] w_ptr_next;
  logic            w_found;
  logic            w_gap_done;
  logic            w_issue;
  logic            w_granted;
  logic            w_tmo_hit;

  assign w_elig     = r_pending & ~i_vec_mask;
  assign w_gap_done = (r_gap_cnt == 4'(GAP_CYC - 1));
  assign w_tmo_hit  = (r_tmo_cnt == 8'(GRANT_TIMEOUT - 1));
  assign w_ptr_next = (w_sel == VECW'(NVEC - 1)) ? {VECW{1'b0}} : (w_sel + VECW'(1));

  // The last GAP cycle doubles as IDLE so back-to-back requests see exactly GAP_CYC low cycles.
  assign w_issue   = w_found && ((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_gap_done));
  assign w_granted = LP_GRANT && (r_state == ST_REQ) && bus.intx_msi_grant;

  // Round-robin search over unmasked pending vectors, starting at the pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = {VECW{1'b0}};
    w_idx   = {(VECW+1){1'b0}};
    for (int i = 0; i < NVEC; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (VECW+1)'(i);
      if (w_idx >= (VECW+1)'(NVEC)) begin
        w_idx = w_idx - (VECW+1)'(NVEC);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && w_elig[w_idx[VECW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[VECW-1:0];
      end else begin
        w_found = w_found;
        w_sel   = w_sel;
      end
    end
  end

  // Service clears the pending bit at issue (fire-and-forget) or at grant (handshake).
  always_comb begin
    w_clr = {NVEC{1'b0}};
    if (w_issue && !LP_GRANT) begin
      w_clr[w_sel] = 1'b1;
    end else if (w_granted) begin
      w_clr[r_vec] = 1'b1;
    end else begin
      w_clr = {NVEC{1'b0}};
    end
  end

  // A coinciding new event wins over the service clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= {NVEC{1'b0}};
    end else begin
      r_pending <= (r_pending & ~w_clr) | i_irq_src;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= {VECW{1'b0}};
      r_vec     <= {VECW{1'b0}};
      r_req     <= 1'b0;
      r_tmo_err <= 1'b0;
      r_tmo_cnt <= 8'd0;
      r_gap_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tmo_err <= 1'b0;
          if (w_issue) begin
            r_state   <= ST_REQ;
            r_req     <= 1'b1;
            r_vec     <= w_sel;
            r_rr_ptr  <= w_ptr_next;
            r_tmo_cnt <= 8'd0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (!LP_GRANT || bus.intx_msi_grant) begin
            r_state   <= ST_GAP;
            r_req     <= 1'b0;
            r_gap_cnt <= 4'd0;
            r_tmo_err <= 1'b0;
          end else if (w_tmo_hit) begin
            // Pending stays set; the pointer already moved past this vector at issue.
            r_state   <= ST_GAP;
            r_req     <= 1'b0;
            r_gap_cnt <= 4'd0;
            r_tmo_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
            r_tmo_err <= 1'b0;
          end
        end
        ST_GAP: begin
          r_tmo_err <= 1'b0;
          if (w_gap_done) begin
            if (w_issue) begin
              r_state   <= ST_REQ;
              r_req     <= 1'b1;
              r_vec     <= w_sel;
              r_rr_ptr  <= w_ptr_next;
              r_tmo_cnt <= 8'd0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_req     <= 1'b0;
          r_tmo_err <= 1'b0;
        end
      endcase
    end
  end

  assign bus.intx_msi_request = r_req;
  assign bus.intx_msi_vector  = r_vec;
  assign o_pending            = r_pending;
  assign o_timeout_err        = r_tmo_err;

endmodule
